// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller: field widths, FSM
// state encoding, opcode/funct values, and the encodings of the ALU control,
// ALU B-source and next-PC-source selects.
package mc_ctrl_pkg;

    localparam int OP_W     = 6;
    localparam int FUNCT_W  = 6;
    localparam int ALUCTL_W = 3;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_RTEXE,
        S_RTWB,
        S_BEQEX,
        S_ADDIEX,
        S_ADDIWB,
        S_JEX
    } state_t;

    // Selects how the ALU decoder chooses an operation.
    typedef enum logic [1:0] {
        ALUOP_ADD,
        ALUOP_SUB,
        ALUOP_FUNCT
    } aluop_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

    localparam logic [ALUCTL_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALUCTL_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALUCTL_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALUCTL_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALUCTL_W-1:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational ALU control decoder.
// Ports:
//   i_aluop        operation class: add, subtract, or decode from funct
//   i_funct        funct field of the current instruction
//   o_alucontrol   ALU operation select
//   o_funct_valid  funct is one of the supported R-type operations
//                  (independent of i_aluop so it can gate the writeback state)
module mc_alu_decoder
    import mc_ctrl_pkg::*;
(
    input  aluop_t              i_aluop,
    input  logic [FUNCT_W-1:0]  i_funct,
    output logic [ALUCTL_W-1:0] o_alucontrol,
    output logic                o_funct_valid
);

    logic [ALUCTL_W-1:0] w_funct_ctl;

    always_comb begin
        // NOTE: every combinational output gets a default before the case so
        // no path leaves it unassigned, which would infer a latch.
        w_funct_ctl   = ALU_ADD;
        o_funct_valid = 1'b1;
        case (i_funct)
            FN_ADD:  w_funct_ctl = ALU_ADD;
            FN_SUB:  w_funct_ctl = ALU_SUB;
            FN_AND:  w_funct_ctl = ALU_AND;
            FN_OR:   w_funct_ctl = ALU_OR;
            FN_SLT:  w_funct_ctl = ALU_SLT;
            default: o_funct_valid = 1'b0;
        endcase
    end

    always_comb begin
        o_alucontrol = ALU_ADD;
        case (i_aluop)
            ALUOP_SUB:   o_alucontrol = ALU_SUB;
            ALUOP_FUNCT: o_alucontrol = w_funct_ctl;
            default:     o_alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle sequencer for the MIPS datapath. A Moore FSM walks each
// instruction through fetch/decode/execute/writeback, sharing one memory port
// and one ALU, stalls on mem_ready, and flags unsupported opcodes/functs.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   op, funct          instruction register fields
//   zero               ALU zero flag (branch resolution)
//   mem_ready          memory completes the current access this cycle
//   mem_req, iord, memwrite, irwrite            memory / IR controls
//   regwrite, regdst, memtoreg                  register-file controls
//   alusrca, alusrcb, alucontrol                ALU controls
//   pcsrc, pcen                                 PC controls
//   illegal_op         sticky flag, cleared only by reset
module mc_controller
    import mc_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [OP_W-1:0]     op,
    input  logic [FUNCT_W-1:0]  funct,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                iord,
    output logic                memwrite,
    output logic                irwrite,
    output logic                regwrite,
    output logic                regdst,
    output logic                memtoreg,
    output logic                alusrca,
    output logic [1:0]          alusrcb,
    output logic [1:0]          pcsrc,
    output logic [ALUCTL_W-1:0] alucontrol,
    output logic                pcen,
    output logic                illegal_op
);

    state_t r_state;
    state_t w_next_state;
    logic   r_illegal;
    logic   w_set_illegal;
    logic   w_pcwrite;
    logic   w_branch;
    logic   w_funct_valid;
    aluop_t w_aluop;

    mc_alu_decoder u_alu_decoder (
        .i_aluop       (w_aluop),
        .i_funct       (funct),
        .o_alucontrol  (alucontrol),
        .o_funct_valid (w_funct_valid)
    );

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_set_illegal)
                r_illegal <= 1'b1;
        end
    end

    assign illegal_op = r_illegal;

    // Next-state logic.
    always_comb begin
        w_next_state  = r_state;
        w_set_illegal = 1'b0;
        case (r_state)
            S_FETCH:  if (mem_ready) w_next_state = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_RTYPE:     w_next_state = S_RTEXE;
                    OP_BEQ:       w_next_state = S_BEQEX;
                    OP_ADDI:      w_next_state = S_ADDIEX;
                    OP_J:         w_next_state = S_JEX;
                    default: begin
                        w_next_state  = S_FETCH;
                        w_set_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: w_next_state = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) w_next_state = S_MEMWB;
            S_MEMWR:  if (mem_ready) w_next_state = S_FETCH;
            S_RTEXE: begin
                w_next_state  = S_RTWB;
                w_set_illegal = ~w_funct_valid;
            end
            S_ADDIEX: w_next_state = S_ADDIWB;
            default:  w_next_state = S_FETCH;
        endcase
    end

    // Output decode. Strobes that change architectural state are masked
    // while reset is held so an interrupted instruction leaves no trace.
    always_comb begin
        mem_req   = 1'b0;
        iord      = 1'b0;
        memwrite  = 1'b0;
        irwrite   = 1'b0;
        regwrite  = 1'b0;
        regdst    = 1'b0;
        memtoreg  = 1'b0;
        alusrca   = 1'b0;
        alusrcb   = SRCB_REGB;
        pcsrc     = PCSRC_ALU;
        w_aluop   = ALUOP_ADD;
        w_pcwrite = 1'b0;
        w_branch  = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alusrcb   = SRCB_FOUR;
                // IR load and PC+4 commit only when the fetch completes.
                irwrite   = mem_ready;
                w_pcwrite = mem_ready;
            end
            S_DECODE: alusrcb = SRCB_IMMSH;
            S_MEMADR, S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWR: begin
                mem_req  = 1'b1;
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            S_RTEXE: begin
                alusrca = 1'b1;
                w_aluop = ALUOP_FUNCT;
            end
            S_RTWB: begin
                regwrite = w_funct_valid;
                regdst   = 1'b1;
            end
            S_ADDIWB: regwrite = 1'b1;
            S_BEQEX: begin
                alusrca  = 1'b1;
                w_aluop  = ALUOP_SUB;
                pcsrc    = PCSRC_ALUOUT;
                w_branch = 1'b1;
            end
            S_JEX: begin
                pcsrc     = PCSRC_JUMP;
                w_pcwrite = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            regwrite = 1'b0;
            memwrite = 1'b0;
            irwrite  = 1'b0;
        end
    end

    assign pcen = (w_pcwrite | (w_branch & zero)) & ~reset;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller. A per-instruction reference model
// expands each instruction (with chosen wait-state counts) into the list of
// expected per-cycle control vectors, which are then replayed against the DUT.
module tb_mc_controller;

    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] alucontrol;
        logic       pcen;
        logic       illegal_op;
    } obs_t;

    typedef enum int {K_LW, K_SW, K_R, K_BEQ, K_ADDI, K_J, K_BAD} kind_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    obs_t       dut_o;

    int checks = 0;
    int errors = 0;

    obs_t  q_exp[$];
    logic  q_rdy[$];
    logic  q_zero[$];
    string q_tag[$];
    logic  m_illegal;

    always #5 clk = ~clk;

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (dut_o.mem_req),
        .iord       (dut_o.iord),
        .memwrite   (dut_o.memwrite),
        .irwrite    (dut_o.irwrite),
        .regwrite   (dut_o.regwrite),
        .regdst     (dut_o.regdst),
        .memtoreg   (dut_o.memtoreg),
        .alusrca    (dut_o.alusrca),
        .alusrcb    (dut_o.alusrcb),
        .pcsrc      (dut_o.pcsrc),
        .alucontrol (dut_o.alucontrol),
        .pcen       (dut_o.pcen),
        .illegal_op (dut_o.illegal_op)
    );

    // ---------------- reference model ----------------
    function automatic logic [2:0] ref_alu(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic logic ref_funct_ok(input logic [5:0] f);
        return (f == 6'b100000) || (f == 6'b100010) || (f == 6'b100100) ||
               (f == 6'b100101) || (f == 6'b101010);
    endfunction

    function automatic obs_t quiet();
        obs_t e;
        e = '0;
        e.alucontrol = 3'b010;
        return e;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [5:0] kind_op(input kind_t k);
        case (k)
            K_LW:    return 6'b100011;
            K_SW:    return 6'b101011;
            K_R:     return 6'b000000;
            K_BEQ:   return 6'b000100;
            K_ADDI:  return 6'b001000;
            K_J:     return 6'b000010;
            default: return 6'b111111;
        endcase
    endfunction

    task automatic push(input string tag, input obs_t e, input logic rdy, input logic z);
        e.illegal_op = m_illegal;
        q_exp.push_back(e);
        q_rdy.push_back(rdy);
        q_zero.push_back(z);
        q_tag.push_back(tag);
    endtask

    task automatic clear_q();
        q_exp.delete();
        q_rdy.delete();
        q_zero.delete();
        q_tag.delete();
    endtask

    // Expand one instruction into its expected cycle-by-cycle controls.
    // wf / wm are wait cycles before the fetch / data access completes.
    task automatic model_instr(input kind_t k, input logic [5:0] f,
                               input int wf, input int wm, input logic z);
        obs_t e;
        for (int i = 0; i < wf; i++) begin
            e = quiet(); e.mem_req = 1'b1; e.alusrcb = 2'b01;
            push("fetch_wait", e, 1'b0, rbit());
        end
        e = quiet(); e.mem_req = 1'b1; e.alusrcb = 2'b01; e.irwrite = 1'b1; e.pcen = 1'b1;
        push("fetch", e, 1'b1, rbit());
        e = quiet(); e.alusrcb = 2'b11;
        push("decode", e, rbit(), rbit());
        case (k)
            K_LW, K_SW: begin
                e = quiet(); e.alusrca = 1'b1; e.alusrcb = 2'b10;
                push("memadr", e, rbit(), rbit());
                for (int i = 0; i <= wm; i++) begin
                    e = quiet(); e.mem_req = 1'b1; e.iord = 1'b1;
                    e.memwrite = (k == K_SW);
                    push((k == K_SW) ? "memwr" : "memrd", e, (i == wm), rbit());
                end
                if (k == K_LW) begin
                    e = quiet(); e.regwrite = 1'b1; e.memtoreg = 1'b1;
                    push("memwb", e, rbit(), rbit());
                end
            end
            K_R: begin
                e = quiet(); e.alusrca = 1'b1; e.alucontrol = ref_alu(f);
                push("rtexe", e, rbit(), rbit());
                if (!ref_funct_ok(f)) m_illegal = 1'b1;
                e = quiet(); e.regdst = 1'b1; e.regwrite = ref_funct_ok(f);
                push("rtwb", e, rbit(), rbit());
            end
            K_ADDI: begin
                e = quiet(); e.alusrca = 1'b1; e.alusrcb = 2'b10;
                push("addiex", e, rbit(), rbit());
                e = quiet(); e.regwrite = 1'b1;
                push("addiwb", e, rbit(), rbit());
            end
            K_BEQ: begin
                e = quiet(); e.alusrca = 1'b1; e.alucontrol = 3'b110; e.pcsrc = 2'b01;
                e.pcen = z;
                push("beqex", e, rbit(), z);
            end
            K_J: begin
                e = quiet(); e.pcsrc = 2'b10; e.pcen = 1'b1;
                push("jex", e, rbit(), rbit());
            end
            default: m_illegal = 1'b1;
        endcase
    endtask

    // One clock: drive inputs just after the rising edge, sample at the falling edge.
    task automatic drive_cycle(input logic [5:0] o, input logic [5:0] f,
                               input logic rdy, input logic z, output obs_t got);
        @(posedge clk);
        #1;
        op = o; funct = f; mem_ready = rdy; zero = z;
        @(negedge clk);
        got = dut_o;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        obs_t got, e;
        reset = 1'b1; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;
        m_illegal = 1'b0;
        repeat (2) @(posedge clk);
        drive_cycle(6'b000000, 6'b0, 1'b1, 1'b1, got);
        e = quiet(); e.mem_req = 1'b1; e.alusrcb = 2'b01;
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL reset_hold: got %b want %b", got, e);
        end
        reset = 1'b0; mem_ready = 1'b0;
        drive_cycle(6'b000000, 6'b0, 1'b0, 1'b0, got);
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL reset_after: got %b want %b", got, e);
        end
    endtask

    task automatic test_lw();
        obs_t got;
        clear_q();
        model_instr(K_LW, 6'b0, 0, 0, 1'b0);
        checks++;
        if (q_exp.size() != 5) begin
            errors++;
            $display("FAIL lw_len: got %0d want 5", q_exp.size());
        end
        foreach (q_exp[i]) begin
            drive_cycle(kind_op(K_LW), 6'b0, q_rdy[i], q_zero[i], got);
            checks++;
            if (got !== q_exp[i]) begin
                errors++;
                $display("FAIL lw.%s[%0d]: got %b want %b", q_tag[i], i, got, q_exp[i]);
            end
        end
    endtask

    task automatic test_sw_wait();
        obs_t got;
        clear_q();
        model_instr(K_SW, 6'b0, 1, 2, 1'b0);
        foreach (q_exp[i]) begin
            drive_cycle(kind_op(K_SW), 6'b0, q_rdy[i], q_zero[i], got);
            checks++;
            if (got !== q_exp[i]) begin
                errors++;
                $display("FAIL sw.%s[%0d]: got %b want %b", q_tag[i], i, got, q_exp[i]);
            end
        end
    endtask

    task automatic test_rtype();
        obs_t got;
        logic [5:0] fl[3];
        fl[0] = 6'b100000; fl[1] = 6'b101010; fl[2] = 6'b100100;
        for (int n = 0; n < 3; n++) begin
            clear_q();
            model_instr(K_R, fl[n], 0, 0, 1'b0);
            foreach (q_exp[i]) begin
                drive_cycle(kind_op(K_R), fl[n], q_rdy[i], q_zero[i], got);
                checks++;
                if (got !== q_exp[i]) begin
                    errors++;
                    $display("FAIL r%0d.%s[%0d]: got %b want %b", n, q_tag[i], i, got, q_exp[i]);
                end
            end
        end
    endtask

    task automatic test_beq();
        obs_t got;
        for (int n = 0; n < 2; n++) begin
            clear_q();
            model_instr(K_BEQ, 6'b0, 0, 0, (n == 0));
            model_instr(K_J, 6'b0, 0, 0, 1'b0);
            foreach (q_exp[i]) begin
                drive_cycle((i < 3) ? kind_op(K_BEQ) : kind_op(K_J), 6'b0,
                            q_rdy[i], q_zero[i], got);
                checks++;
                if (got !== q_exp[i]) begin
                    errors++;
                    $display("FAIL beq%0d.%s[%0d]: got %b want %b", n, q_tag[i], i, got, q_exp[i]);
                end
            end
        end
    endtask

    task automatic test_illegal();
        obs_t got;
        kind_t ks[3];
        logic [5:0] fs[3];
        ks[0] = K_BAD; ks[1] = K_ADDI; ks[2] = K_R;
        fs[0] = 6'b0;  fs[1] = 6'b0;   fs[2] = 6'b000000;
        for (int n = 0; n < 3; n++) begin
            clear_q();
            model_instr(ks[n], fs[n], 0, 0, 1'b0);
            foreach (q_exp[i]) begin
                drive_cycle(kind_op(ks[n]), fs[n], q_rdy[i], q_zero[i], got);
                checks++;
                if (got !== q_exp[i]) begin
                    errors++;
                    $display("FAIL ill%0d.%s[%0d]: got %b want %b", n, q_tag[i], i, got, q_exp[i]);
                end
            end
        end
    endtask

    task automatic test_reset_memwr();
        obs_t got, e;
        clear_q();
        model_instr(K_SW, 6'b0, 0, 0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(kind_op(K_SW), 6'b0, q_rdy[i], q_zero[i], got);
            checks++;
            if (got !== q_exp[i]) begin
                errors++;
                $display("FAIL rstwr.%s[%0d]: got %b want %b", q_tag[i], i, got, q_exp[i]);
            end
        end
        // Reset arrives while the store is in flight and memory is ready.
        @(posedge clk);
        #1;
        reset = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        got = dut_o;
        e = q_exp[3];
        e.memwrite = 1'b0;
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL rstwr.abandon: got %b want %b", got, e);
        end
        m_illegal = 1'b0;
        drive_cycle(kind_op(K_SW), 6'b0, 1'b0, 1'b0, got);
        reset = 1'b0;
        drive_cycle(kind_op(K_SW), 6'b0, 1'b0, 1'b0, got);
        e = quiet(); e.mem_req = 1'b1; e.alusrcb = 2'b01;
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL rstwr.fetch: got %b want %b", got, e);
        end
    endtask

    task automatic test_random();
        obs_t got;
        kind_t k;
        logic [5:0] f;
        for (int n = 0; n < 60; n++) begin
            k = kind_t'($urandom_range(0, 6));
            f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'b100000 | 6'($urandom_range(0, 10));
            clear_q();
            model_instr(k, f, $urandom_range(0, 3), $urandom_range(0, 3), rbit());
            foreach (q_exp[i]) begin
                drive_cycle(kind_op(k), f, q_rdy[i], q_zero[i], got);
                checks++;
                if (got !== q_exp[i]) begin
                    errors++;
                    $display("FAIL rnd%0d.%s[%0d]: got %b want %b", n, q_tag[i], i, got, q_exp[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_wait();
        test_rtype();
        test_beq();
        test_illegal();
        test_reset_memwr();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
